// File: rtl/soft_ides_align.sv
// Soft deserializer: CHANNELS serial lanes into RATIO-bit words, divided word clock,
// and per-lane bitslip alignment against a training word.
module soft_ides_align #(
    parameter int                RATIO         = 8,
    parameter int                CHANNELS      = 1,
    parameter logic [RATIO-1:0]  TRAIN_PATTERN = 8'h6A,
    parameter int                LOCK_COUNT    = 4
) (
    input  logic                         fclk_i,
    input  logic                         rst,
    input  logic [CHANNELS-1:0]          data_i,
    input  logic                         align_en,
    output logic                         pclk_o,
    output logic [CHANNELS*RATIO-1:0]    q_o,
    output logic                         q_valid_o,
    output logic [CHANNELS*4-1:0]        offset_o,
    output logic [CHANNELS-1:0]          locked_o,
    output logic [CHANNELS-1:0]          align_err_o
);

    localparam int CW = $clog2(RATIO);
    localparam int SW = $clog2(2*RATIO+1);

    typedef enum logic [1:0] {IDLE, CHECK, SLIP, LOCKED} state_t;

    logic [CW-1:0] r_cnt, w_cnt_n;
    logic          r_pclk, r_valid, w_cap;

    always_comb begin
        w_cap   = (r_cnt == CW'(RATIO-1));
        w_cnt_n = w_cap ? '0 : r_cnt + 1'b1;
    end

    always_ff @(posedge fclk_i) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_pclk  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_n;
            r_pclk  <= (w_cnt_n >= CW'(RATIO/2));
            r_valid <= w_cap;
        end
    end

    assign pclk_o    = r_pclk;
    assign q_valid_o = r_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        // Windows read the post-update history from bit 1 upward, so bits [1:0] never need storing.
        logic [2*RATIO-1:2] r_hist;
        logic [2*RATIO-1:1] w_hist_n;
        logic [RATIO-1:0]   w_win, r_q;
        state_t             r_st, w_st_n;
        logic [3:0]         r_off, w_off_n;
        logic [SW-1:0]      r_slip, w_slip_n;
        logic [3:0]         r_match, w_match_n;
        logic               r_err, w_err_n;

        always_comb begin
            w_hist_n = {data_i[c], r_hist};
            w_win    = w_hist_n[RATIO +: RATIO];
            for (int unsigned k = 1; k < RATIO; k++) begin
                if (r_off == 4'(k)) w_win = w_hist_n[RATIO-k +: RATIO];
            end
        end

        always_comb begin
            w_st_n    = r_st;
            w_off_n   = r_off;
            w_slip_n  = r_slip;
            w_match_n = r_match;
            w_err_n   = r_err;
            if (!align_en) begin
                w_st_n    = IDLE;
                w_slip_n  = '0;
                w_match_n = '0;
                w_err_n   = 1'b0;
            end else begin
                case (r_st)
                    IDLE: begin
                        w_st_n    = CHECK;
                        w_slip_n  = '0;
                        w_match_n = '0;
                        w_err_n   = 1'b0;
                    end
                    CHECK: if (w_cap) begin
                        if (w_win == TRAIN_PATTERN) begin
                            if (r_match == 4'(LOCK_COUNT-1)) w_st_n = LOCKED;
                            else                             w_match_n = r_match + 4'd1;
                        end else begin
                            w_match_n = '0;
                            w_off_n   = (r_off == 4'(RATIO-1)) ? 4'd0 : r_off + 4'd1;
                            // Once the slip budget is spent, keep slipping every word without settling.
                            if (r_slip >= SW'(2*RATIO-1)) begin
                                w_slip_n = SW'(2*RATIO);
                                w_err_n  = 1'b1;
                                w_st_n   = CHECK;
                            end else begin
                                w_slip_n = r_slip + 1'b1;
                                w_st_n   = SLIP;
                            end
                        end
                    end
                    SLIP:   if (w_cap) w_st_n = CHECK;
                    LOCKED: w_st_n = LOCKED;
                endcase
            end
        end

        always_ff @(posedge fclk_i) begin
            if (!rst) begin
                r_hist  <= '0;
                r_q     <= '0;
                r_st    <= IDLE;
                r_off   <= '0;
                r_slip  <= '0;
                r_match <= '0;
                r_err   <= 1'b0;
            end else begin
                r_hist  <= w_hist_n[2*RATIO-1:2];
                if (w_cap) r_q <= w_win;
                r_st    <= w_st_n;
                r_off   <= w_off_n;
                r_slip  <= w_slip_n;
                r_match <= w_match_n;
                r_err   <= w_err_n;
            end
        end

        assign q_o[c*RATIO +: RATIO] = r_q;
        assign offset_o[c*4 +: 4]    = r_off;
        assign locked_o[c]           = (r_st == LOCKED);
        assign align_err_o[c]        = r_err;
    end

endmodule

// File: tb/tb_soft_ides_align.sv
// Directed bench for soft_ides_align: an 8:1 single-lane instance and a 4:1 two-lane instance.
module tb_soft_ides_align;

    logic fclk_i;
    initial begin
        fclk_i = 1'b0;
        forever #5 fclk_i = ~fclk_i;
    end

    logic       rst_a, align_a, pclk_a, qv_a;
    logic [0:0] data_a, lk_a, err_a;
    logic [7:0] q_a;
    logic [3:0] off_a;

    logic       rst_b, align_b, pclk_b, qv_b;
    logic [1:0] data_b, lk_b, err_b;
    logic [7:0] q_b, off_b;

    int total = 0;
    int bad   = 0;

    soft_ides_align #(.RATIO(8), .CHANNELS(1), .TRAIN_PATTERN(8'h6A), .LOCK_COUNT(4)) u_a (
        .fclk_i(fclk_i), .rst(rst_a), .data_i(data_a), .align_en(align_a),
        .pclk_o(pclk_a), .q_o(q_a), .q_valid_o(qv_a), .offset_o(off_a),
        .locked_o(lk_a), .align_err_o(err_a)
    );

    soft_ides_align #(.RATIO(4), .CHANNELS(2), .TRAIN_PATTERN(4'b0001), .LOCK_COUNT(4)) u_b (
        .fclk_i(fclk_i), .rst(rst_b), .data_i(data_b), .align_en(align_b),
        .pclk_o(pclk_b), .q_o(q_b), .q_valid_o(qv_b), .offset_o(off_b),
        .locked_o(lk_b), .align_err_o(err_b)
    );

    // Leaves the bench just after a negedge with rst_a low; the caller releases there.
    task hold_reset_a(input int n);
        @(negedge fclk_i);
        rst_a = 1'b0;
        repeat (n) begin
            @(negedge fclk_i);
            data_a = 1'($urandom_range(0, 1));
        end
    endtask

    task test_reset;
        logic e;
        align_a = 1'b0;
        hold_reset_a(20);
        total++;
        if (q_a !== 8'h00) begin bad++; $display("FAIL rst_q: got=%h exp=00", q_a); end
        total++;
        if ({qv_a, pclk_a, off_a, lk_a, err_a} !== 8'h00) begin
            bad++; $display("FAIL rst_flags: got=%b exp=00000000", {qv_a, pclk_a, off_a, lk_a, err_a});
        end
        rst_a  = 1'b1;
        data_a = 1'b0;
        for (int t = 0; t <= 17; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_a = 1'b0;
            e = ((t % 8) >= 4);
            total++;
            if (pclk_a !== e) begin bad++; $display("FAIL rst_pclk t=%0d: got=%b exp=%b", t, pclk_a, e); end
            e = (t == 8 || t == 16);
            total++;
            if (qv_a !== e) begin bad++; $display("FAIL rst_qvalid t=%0d: got=%b exp=%b", t, qv_a, e); end
        end
    endtask

    task test_capture;
        logic [7:0] wd [4];
        wd[0] = 8'hA5; wd[1] = 8'h3C; wd[2] = 8'h00; wd[3] = 8'h00;
        align_a = 1'b0;
        hold_reset_a(4);
        rst_a = 1'b1;
        for (int t = 0; t <= 24; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_a = wd[t/8][t%8];
            if (t == 8) begin
                total++;
                if (q_a !== 8'hA5 || qv_a !== 1'b1) begin
                    bad++; $display("FAIL cap_a5: q=%h v=%b exp q=a5 v=1", q_a, qv_a);
                end
            end
            if (t == 9) begin
                total++;
                if (q_a !== 8'hA5 || qv_a !== 1'b0) begin
                    bad++; $display("FAIL cap_hold: q=%h v=%b exp q=a5 v=0", q_a, qv_a);
                end
            end
            if (t == 16) begin
                total++;
                if (q_a !== 8'h3C || qv_a !== 1'b1) begin
                    bad++; $display("FAIL cap_3c: q=%h v=%b exp q=3c v=1", q_a, qv_a);
                end
            end
        end
    endtask

    // Releases reset and streams 8'h6A arranged so that offset 3 is the aligned phase.
    task align_run;
        logic [7:0] pat;
        int n;
        pat     = 8'h6A;
        align_a = 1'b1;
        rst_a   = 1'b1;
        for (int t = 0; t <= 8*12; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_a = pat[(t+3)%8];
            n = t / 8;
            if (t % 8 == 0 && t > 0) begin
                if (n == 1) begin
                    total++;
                    if (off_a !== 4'd1) begin bad++; $display("FAIL al_off1: got=%0d exp=1", off_a); end
                end
                if (n == 3) begin
                    total++;
                    if (off_a !== 4'd2) begin bad++; $display("FAIL al_off2: got=%0d exp=2", off_a); end
                end
                if (n == 5) begin
                    total++;
                    if (off_a !== 4'd3 || lk_a !== 1'b0) begin
                        bad++; $display("FAIL al_off3: off=%0d lk=%b exp off=3 lk=0", off_a, lk_a);
                    end
                end
                if (n == 9) begin
                    total++;
                    if (lk_a !== 1'b0) begin bad++; $display("FAIL al_early: lk=%b exp=0", lk_a); end
                end
                if (n == 10) begin
                    total++;
                    if (lk_a !== 1'b1 || off_a !== 4'd3 || q_a !== 8'h6A) begin
                        bad++; $display("FAIL al_lock: lk=%b off=%0d q=%h exp lk=1 off=3 q=6a", lk_a, off_a, q_a);
                    end
                end
                if (n == 12) begin
                    total++;
                    if (lk_a !== 1'b1 || q_a !== 8'h6A || qv_a !== 1'b1 || err_a !== 1'b0) begin
                        bad++; $display("FAIL al_steady: lk=%b q=%h v=%b err=%b exp 1 6a 1 0", lk_a, q_a, qv_a, err_a);
                    end
                end
            end
        end
    endtask

    task test_align;
        align_a = 1'b1;
        hold_reset_a(4);
        align_run();
    endtask

    task test_error;
        int n;
        align_a = 1'b1;
        hold_reset_a(4);
        rst_a = 1'b1;
        for (int t = 0; t <= 8*36; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_a = 1'b0;
            n = t / 8;
            if (t == 8*30) begin
                total++;
                if (err_a !== 1'b0 || off_a !== 4'd7) begin
                    bad++; $display("FAIL err_pre: err=%b off=%0d exp err=0 off=7", err_a, off_a);
                end
            end
            if (t == 8*31) begin
                total++;
                if (err_a !== 1'b1 || off_a !== 4'd0 || lk_a !== 1'b0) begin
                    bad++; $display("FAIL err_set: err=%b off=%0d lk=%b exp 1 0 0", err_a, off_a, lk_a);
                end
            end
            if (t == 8*33) begin
                total++;
                if (err_a !== 1'b1 || off_a !== 4'd2) begin
                    bad++; $display("FAIL err_slip: err=%b off=%0d exp err=1 off=2", err_a, off_a);
                end
                align_a = 1'b0;
            end
            if (t == 8*33 + 1) begin
                total++;
                if (err_a !== 1'b0 || off_a !== 4'd2 || lk_a !== 1'b0) begin
                    bad++; $display("FAIL err_clear: err=%b off=%0d lk=%b exp 0 2 0", err_a, off_a, lk_a);
                end
            end
            if (t == 8*36) begin
                total++;
                if (err_a !== 1'b0 || off_a !== 4'd2) begin
                    bad++; $display("FAIL err_frozen: err=%b off=%0d exp err=0 off=2", err_a, off_a);
                end
            end
        end
    endtask

    task test_reset_mid;
        logic [7:0] pat;
        pat     = 8'h6A;
        align_a = 1'b1;
        hold_reset_a(4);
        rst_a = 1'b1;
        for (int t = 0; t <= 28; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_a = pat[(t+3)%8];
            if (t == 24) begin
                total++;
                if (off_a !== 4'd2) begin bad++; $display("FAIL mid_pre: off=%0d exp=2", off_a); end
            end
        end
        rst_a = 1'b0;
        @(negedge fclk_i);
        total++;
        if (off_a !== 4'd0 || lk_a !== 1'b0 || qv_a !== 1'b0 || q_a !== 8'h00 || pclk_a !== 1'b0) begin
            bad++; $display("FAIL mid_rst: off=%0d lk=%b v=%b q=%h pclk=%b exp all 0", off_a, lk_a, qv_a, q_a, pclk_a);
        end
        hold_reset_a(2);
        align_run();
    endtask

    task test_multi;
        logic [3:0] pb;
        logic       e;
        int n;
        pb      = 4'b0001;
        align_b = 1'b1;
        @(negedge fclk_i);
        rst_b = 1'b1;
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) @(negedge fclk_i);
            data_b = {pb[(t+2)%4], pb[(t+1)%4]};
            n = t / 4;
            if (t <= 9) begin
                e = ((t % 4) >= 2);
                total++;
                if (pclk_b !== e) begin bad++; $display("FAIL mc_pclk t=%0d: got=%b exp=%b", t, pclk_b, e); end
            end
            if (t % 4 == 0 && t > 0) begin
                if (n == 1) begin
                    total++;
                    if (off_b !== 8'h11) begin bad++; $display("FAIL mc_off1: got=%h exp=11", off_b); end
                end
                if (n == 6) begin
                    total++;
                    if (lk_b !== 2'b01 || off_b !== 8'h21) begin
                        bad++; $display("FAIL mc_lane0: lk=%b off=%h exp lk=01 off=21", lk_b, off_b);
                    end
                end
                if (n == 7) begin
                    total++;
                    if (lk_b !== 2'b01) begin bad++; $display("FAIL mc_lane1_early: lk=%b exp=01", lk_b); end
                end
                if (n == 8) begin
                    total++;
                    if (lk_b !== 2'b11 || q_b !== 8'h11 || err_b !== 2'b00) begin
                        bad++; $display("FAIL mc_both: lk=%b q=%h err=%b exp 11 11 00", lk_b, q_b, err_b);
                    end
                end
                if (n == 10) begin
                    total++;
                    if (lk_b !== 2'b11 || off_b !== 8'h21 || qv_b !== 1'b1) begin
                        bad++; $display("FAIL mc_steady: lk=%b off=%h v=%b exp 11 21 1", lk_b, off_b, qv_b);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_a = 1'b0; align_a = 1'b0; data_a = '0;
        rst_b = 1'b0; align_b = 1'b0; data_b = '0;
        test_reset();
        test_capture();
        test_align();
        test_error();
        test_reset_mid();
        test_multi();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
